// File: rtl/capture_ctrl.sv
// Triggered sample capture into a double-buffered frame store.
// Writes one frame per trigger and swaps banks on vertical blanking.
module capture_ctrl #(
    parameter int SAMPLES      = 256,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] adc_data,
    input  logic        adc_valid,
    input  logic [11:0] trig_level,
    input  logic        trig_auto,
    input  logic [3:0]  decim,
    input  logic        vblnk,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic        wr_bank,
    output logic        disp_bank,
    output logic        frame_done
);

    localparam int TW = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [7:0] PRE_LAST = 8'(SAMPLES - 2);

    typedef enum logic [1:0] {ARM, WAIT_TRIG, CAPTURE, HOLD} state_t;

    state_t       state;
    logic [3:0]   dcnt;
    logic [TW-1:0] tcnt;
    logic [11:0]  prev_sample;
    logic         vblnk_q;

    logic accept;
    logic rise;
    logic hit;
    logic timeout;

    assign accept  = adc_valid && (state != HOLD) && (dcnt == decim);
    assign rise    = vblnk && !vblnk_q;
    assign hit     = (prev_sample < trig_level) && (adc_data >= trig_level);
    // tcnt counts earlier waiting samples, so the current one is number tcnt+1
    assign timeout = trig_auto && (tcnt >= TW'(AUTO_TIMEOUT - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARM;
            wr_en       <= 1'b0;
            wr_addr     <= 8'd0;
            wr_data     <= 12'd0;
            wr_bank     <= 1'b0;
            disp_bank   <= 1'b1;
            frame_done  <= 1'b0;
            dcnt        <= 4'd0;
            tcnt        <= '0;
            prev_sample <= 12'd0;
            vblnk_q     <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            vblnk_q    <= vblnk;
            if (adc_valid && state != HOLD)
                dcnt <= accept ? 4'd0 : dcnt + 4'd1;
            unique case (state)
                ARM: begin
                    if (accept) begin
                        prev_sample <= adc_data;
                        state       <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (accept) begin
                        prev_sample <= adc_data;
                        if (!(&tcnt))
                            tcnt <= tcnt + 1'b1;
                        if (hit || timeout) begin
                            wr_en   <= 1'b1;
                            wr_addr <= 8'd0;
                            wr_data <= adc_data;
                            state   <= (SAMPLES == 1) ? HOLD : CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_addr + 8'd1;
                        wr_data <= adc_data;
                        if (wr_addr == PRE_LAST)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    // an edge coinciding with the final write is not a swap
                    if (rise && !wr_en) begin
                        wr_bank    <= ~wr_bank;
                        disp_bank  <= wr_bank;
                        frame_done <= 1'b1;
                        wr_addr    <= 8'd0;
                        dcnt       <= 4'd0;
                        tcnt       <= '0;
                        state      <= ARM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed scenarios plus
// randomized traffic compared against a frame-level reference model.
module tb_capture_ctrl;

    localparam int SAMPLES = 256;
    localparam int AUTO    = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] adc_data = 12'd0;
    logic        adc_valid = 1'b0;
    logic [11:0] trig_level = 12'd100;
    logic        trig_auto = 1'b0;
    logic [3:0]  decim = 4'd0;
    logic        vblnk = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic        wr_bank;
    logic        disp_bank;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    capture_ctrl #(.SAMPLES(SAMPLES), .AUTO_TIMEOUT(AUTO)) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .trig_level(trig_level), .trig_auto(trig_auto), .decim(decim),
        .vblnk(vblnk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_bank(wr_bank), .disp_bank(disp_bank), .frame_done(frame_done)
    );

    // Reference model: frame progress expressed as "samples written so far".
    bit m_have_prev;
    int m_prev;
    int m_wait;
    int m_nwr;
    int m_dc;
    bit m_vq;
    bit m_bank;
    bit e_wr = 1'b0;
    int e_addr = 0;
    int e_data = 0;
    bit e_fd = 1'b0;

    task automatic tick();
        bit was = e_wr;
        bit acc = 1'b0;
        int d = int'(adc_data);
        int lv = int'(trig_level);
        e_wr = 1'b0;
        e_fd = 1'b0;
        if (rst) begin
            m_have_prev = 0; m_prev = 0; m_wait = 0; m_nwr = 0;
            m_dc = 0; m_vq = 0; m_bank = 0; e_addr = 0; e_data = 0;
        end else begin
            if (m_nwr < SAMPLES && adc_valid) begin
                if (m_dc == int'(decim)) begin
                    acc = 1'b1;
                    m_dc = 0;
                end else begin
                    m_dc = (m_dc + 1) % 16;
                end
            end
            if (m_nwr == SAMPLES) begin
                if (vblnk && !m_vq && !was) begin
                    m_bank = !m_bank; e_fd = 1'b1; e_addr = 0; m_nwr = 0;
                    m_have_prev = 0; m_wait = 0; m_dc = 0;
                end
            end else if (acc) begin
                if (!m_have_prev) begin
                    m_have_prev = 1;
                    m_prev = d;
                end else if (m_nwr == 0) begin
                    m_wait++;
                    if ((m_prev < lv && d >= lv) || (trig_auto && m_wait >= AUTO - 1)) begin
                        e_wr = 1'b1; e_addr = 0; e_data = d; m_nwr = 1;
                    end
                    m_prev = d;
                end else begin
                    e_wr = 1'b1; e_addr = m_nwr; e_data = d; m_nwr++;
                end
            end
            m_vq = vblnk;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; adc_valid = 1'b0; vblnk = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_done} !== {1'b0, 8'd0, 12'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got en=%b addr=%0d data=%0d wb=%b db=%b fd=%b want 0 0 0 0 1 0",
                     wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        int nw = 0;
        int first_c = -1;
        int last_c = -1;
        int stray = 0;
        decim = 4'd0; trig_level = 12'd100; trig_auto = 1'b0;
        adc_valid = 1'b1; adc_data = 12'd0;
        for (int c = 0; c < 700 && nw < SAMPLES; c++) begin
            tick();
            if (wr_en) begin
                if (nw == 0) first_c = c;
                last_c = c;
                checks++;
                if (wr_addr !== 8'(nw) || wr_data !== 12'(100 + nw) || wr_bank !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp_write: got addr=%0d data=%0d bank=%b want %0d %0d 0",
                             wr_addr, wr_data, wr_bank, nw, 100 + nw);
                end
                nw++;
            end
            adc_data = adc_data + 12'd1;
        end
        checks++;
        if (nw !== SAMPLES || first_c !== 100 || last_c - first_c !== SAMPLES - 1) begin
            errors++;
            $display("FAIL ramp_frame: got writes=%0d first=%0d span=%0d want 256 100 255",
                     nw, first_c, last_c - first_c);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (wr_en) stray++;
            adc_data = adc_data + 12'd1;
        end
        checks++;
        if (stray !== 0 || wr_addr !== 8'd255) begin
            errors++;
            $display("FAIL ramp_hold: got stray=%0d addr=%0d want 0 255", stray, wr_addr);
        end
    endtask

    task automatic test_bank_swap();
        int fd = 0;
        bit got = 1'b0;
        adc_valid = 1'b0;
        vblnk = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (frame_done) fd++;
        end
        vblnk = 1'b0;
        checks++;
        if (fd !== 1 || wr_bank !== 1'b1 || disp_bank !== 1'b0) begin
            errors++;
            $display("FAIL bank_swap: got fd=%0d wb=%b db=%b want 1 1 0", fd, wr_bank, disp_bank);
        end
        adc_valid = 1'b1; adc_data = 12'd0;
        for (int c = 0; c < 300 && !got; c++) begin
            tick();
            if (wr_en) got = 1'b1;
            adc_data = adc_data + 12'd1;
        end
        checks++;
        if (!got || wr_bank !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 12'd100) begin
            errors++;
            $display("FAIL second_frame: got seen=%b bank=%b addr=%0d data=%0d want 1 1 0 100",
                     got, wr_bank, wr_addr, wr_data);
        end
    endtask

    task automatic test_auto_trigger();
        int n = 0;
        int nw = 0;
        bit got = 1'b0;
        pulse_reset();
        decim = 4'd0; trig_level = 12'd100; trig_auto = 1'b1;
        adc_valid = 1'b1; adc_data = 12'd50;
        while (!got && n < 5000) begin
            tick();
            n++;
            if (wr_en) got = 1'b1;
        end
        checks++;
        if (!got || n !== AUTO || wr_addr !== 8'd0 || wr_data !== 12'd50) begin
            errors++;
            $display("FAIL auto_trigger: got seen=%b n=%0d addr=%0d data=%0d want 1 4096 0 50",
                     got, n, wr_addr, wr_data);
        end
        pulse_reset();
        trig_auto = 1'b0; adc_valid = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (wr_en) nw++;
        end
        checks++;
        if (nw !== 0) begin
            errors++;
            $display("FAIL auto_off: got writes=%0d want 0", nw);
        end
    endtask

    task automatic test_decimation();
        int nw = 0;
        int last = 0;
        bit got = 1'b0;
        pulse_reset();
        decim = 4'd3; trig_level = 12'd100; trig_auto = 1'b0;
        adc_valid = 1'b1; adc_data = 12'd0;
        for (int c = 0; c < 1000 && !got; c++) begin
            tick();
            if (wr_en) got = 1'b1;
            adc_data = adc_data + 12'd1;
        end
        nw = got ? 1 : 0;
        for (int c = 1; c < 1024; c++) begin
            tick();
            if (wr_en) begin
                checks++;
                if (c - last !== 4) begin
                    errors++;
                    $display("FAIL decim_spacing: got gap=%0d want 4", c - last);
                end
                last = c;
                nw++;
            end
            adc_data = adc_data + 12'd1;
        end
        checks++;
        if (nw !== SAMPLES) begin
            errors++;
            $display("FAIL decim_count: got writes=%0d want 256", nw);
        end
        decim = 4'd0;
    endtask

    task automatic test_reset_mid_frame();
        int nw = 0;
        bit got = 1'b0;
        pulse_reset();
        adc_valid = 1'b1; adc_data = 12'd0; trig_level = 12'd100;
        for (int c = 0; c < 400 && nw < 100; c++) begin
            tick();
            if (wr_en) nw++;
            adc_data = adc_data + 12'd1;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (nw !== 100 || {wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_done} !== {1'b0, 8'd0, 12'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got n=%0d en=%b addr=%0d data=%0d wb=%b db=%b fd=%b want 100 0 0 0 0 1 0",
                     nw, wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_done);
        end
        rst = 1'b0;
        adc_data = 12'd0;
        for (int c = 0; c < 300 && !got; c++) begin
            tick();
            if (wr_en) got = 1'b1;
            adc_data = adc_data + 12'd1;
        end
        checks++;
        if (!got || wr_addr !== 8'd0 || wr_bank !== 1'b0 || wr_data !== 12'd100) begin
            errors++;
            $display("FAIL restart: got seen=%b addr=%0d bank=%b data=%0d want 1 0 0 100",
                     got, wr_addr, wr_bank, wr_data);
        end
    endtask

    task automatic test_same_cycle_edge();
        for (int v = 0; v < 2; v++) begin
            int fd = 0;
            pulse_reset();
            adc_valid = 1'b1; adc_data = 12'd0; trig_level = 12'd100; decim = 4'd0;
            for (int c = 0; c < 700 && m_nwr < SAMPLES - 1; c++) begin
                tick();
                adc_data = adc_data + 12'd1;
            end
            if (v == 0) vblnk = 1'b1;
            tick();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 8'd255) begin
                errors++;
                $display("FAIL last_write_%0d: got en=%b addr=%0d want 1 255", v, wr_en, wr_addr);
            end
            vblnk = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (frame_done) fd++;
            end
            checks++;
            if (fd !== 0 || wr_bank !== 1'b0) begin
                errors++;
                $display("FAIL edge_ignored_%0d: got fd=%0d bank=%b want 0 0", v, fd, wr_bank);
            end
            vblnk = 1'b0;
            tick();
            tick();
            vblnk = 1'b1;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (frame_done) fd++;
            end
            vblnk = 1'b0;
            checks++;
            if (fd !== 1 || wr_bank !== 1'b1 || disp_bank !== 1'b0) begin
                errors++;
                $display("FAIL next_edge_%0d: got fd=%0d wb=%b db=%b want 1 1 0", v, fd, wr_bank, disp_bank);
            end
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 20000; c++) begin
            adc_valid = ($urandom_range(3) != 0);
            adc_data = 12'($urandom_range(4095));
            if ($urandom_range(199) == 0) decim = 4'($urandom_range(3));
            if ($urandom_range(499) == 0) trig_level = 12'($urandom_range(4095));
            if ($urandom_range(999) == 0) trig_auto = !trig_auto;
            if ($urandom_range(49) == 0) vblnk = !vblnk;
            rst = ($urandom_range(2999) == 0);
            tick();
            checks++;
            if ({wr_en, wr_addr, wr_bank, disp_bank, frame_done} !== {e_wr, 8'(e_addr), m_bank, !m_bank, e_fd}
                || (e_wr && wr_data !== 12'(e_data))) begin
                errors++;
                $display("FAIL random_c%0d: got en=%b addr=%0d data=%0d wb=%b db=%b fd=%b want %b %0d %0d %b %b %b",
                         c, wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_done,
                         e_wr, e_addr, e_data, m_bank, !m_bank, e_fd);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bank_swap();
        test_auto_trigger();
        test_decimation();
        test_reset_mid_frame();
        test_same_cycle_edge();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter SAMPLES, default 256, meaning samples per displayed frame.
REQ-002 SHALL have parameter AUTO_TIMEOUT, default 4096, meaning accepted samples without a trigger before auto-trigger.
REQ-003 SHALL have port clk, input, 1, system clock; the only clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port adc_data, input, 12, unsigned ADC sample.
REQ-006 SHALL have port adc_valid, input, 1, adc_data valid this cycle.
REQ-007 SHALL have port trig_level, input, 12, unsigned rising-edge trigger threshold.
REQ-008 SHALL have port trig_auto, input, 1, enables the auto-trigger timeout.
REQ-009 SHALL have port decim, input, 4, keep one of every decim+1 valid samples.
REQ-010 SHALL have port vblnk, input, 1, vertical blanking from VGA timing.
REQ-011 SHALL have port wr_en, output, 1, write strobe to the sample buffer.
REQ-012 SHALL have port wr_addr, output, 8, buffer write index.
REQ-013 SHALL have port wr_data, output, 12, sample to write.
REQ-014 SHALL have port wr_bank, output, 1, bank being written.
REQ-015 SHALL have port disp_bank, output, 1, bank read by draw logic; always the complement of wr_bank.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse on bank swap.

Function
REQ-017 SHALL implement states ARM, WAIT_TRIG, CAPTURE, HOLD.
REQ-018 Decimation: SHALL keep a 4-bit counter that advances only on adc_valid; a sample is accepted when the counter equals decim, which also resets the counter to 0; decim=0 accepts every valid sample.
REQ-019 A decim change mid-frame SHALL take effect at the next counter compare, with no other effect.
REQ-020 ARM: on the first accepted sample, SHALL store it as prev_sample and go to WAIT_TRIG; this sample is not written.
REQ-021 WAIT_TRIG: on each accepted sample, SHALL trigger when prev_sample < trig_level and sample >= trig_level (unsigned); prev_sample then updates.
REQ-022 WAIT_TRIG: SHALL count accepted samples; when trig_auto=1 and the count reaches AUTO_TIMEOUT-1 without a trigger, the current sample SHALL force a trigger.
REQ-023 A trigger SHALL write the triggering sample at wr_addr=0 in the same cycle and go to CAPTURE.
REQ-024 CAPTURE: each accepted sample SHALL assert wr_en for exactly one cycle, with wr_data equal to the sample, and increment wr_addr.
REQ-025 After the write at wr_addr=SAMPLES-1, SHALL go to HOLD with no further writes.
REQ-026 wr_addr SHALL NOT wrap within a frame.
REQ-027 HOLD: SHALL detect the vblnk rising edge using a registered copy of vblnk.
REQ-028 On that edge, SHALL toggle wr_bank, pulse frame_done for one cycle, clear wr_addr and the counters, and go to ARM.
REQ-029 A vblnk edge in the same cycle as the last CAPTURE write SHALL be ignored; the swap waits for the next rising edge.
REQ-030 wr_en SHALL be 0 in ARM and HOLD and on non-accepted cycles.
REQ-031 All outputs SHALL be registered; wr_en, wr_addr and wr_data SHALL appear 1 cycle after the accepting adc_valid cycle.
REQ-032 adc_valid in HOLD SHALL be discarded.
REQ-033 The bank SHALL never change outside HOLD, so the display bank always holds one complete frame.

Reset
REQ-034 While rst=1 at a clk edge, SHALL set state=ARM, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, disp_bank=1, frame_done=0, and clear the decimation counter, timeout counter, prev_sample and vblnk register.
REQ-035 Reset mid-CAPTURE SHALL abandon the partial frame without swapping banks; the first capture after reset SHALL write bank 0.

Verification
REQ-036 Ramp test: decim=0, trig_level=100, adc_valid=1, samples 0,1,2,... -> first write has wr_data=100 at wr_addr=0; 256 consecutive writes follow; wr_addr 255 holds 355; then HOLD.
REQ-037 Bank-swap test: after REQ-036, raise vblnk -> exactly one frame_done pulse; wr_bank 0->1; disp_bank 1->0; next frame writes bank 1.
REQ-038 Auto-trigger test: constant sample 50, trig_level=100, trig_auto=1 -> first write occurs on the 4096th accepted sample after ARM; with trig_auto=0, no writes within 10000 samples.
REQ-039 Decimation test: decim=3, adc_valid=1 for 1024 cycles after trigger -> exactly 256 writes, spaced 4 cycles apart.
REQ-040 Reset-mid-frame test: assert rst after 100 writes -> outputs match REQ-034 on the next cycle; bank stays 0; capture restarts from wr_addr 0.
REQ-041 Same-cycle edge test: vblnk rises in the cycle of the write at wr_addr=255 -> no swap then; swap occurs on the following vblnk rising edge.
